// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen
//
// Purpose: SPI master serial-clock generator. Divides clk down to SCLK and
// issues one-cycle sample_edge / shift_edge strobes that line up with the
// registered sclk transitions. A transfer is framed by a programmable lead
// delay before the first SCLK edge and a trail delay after the last one.
// busy qualifies the downstream word counter and shift register.
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst          synchronous, active-high reset
//   en           level: high keeps SCLK running, low ends after the current period
//   div          SCLK half-period in clk cycles (0 behaves as 1), latched at start
//   cpol         SCLK idle level, latched at start
//   cpha         0: sample on leading edge, 1: sample on trailing edge; latched at start
//   hold         (SCLK_STRETCH_EN only) stalls the next leading SCLK edge
//   sclk         registered SPI clock
//   sample_edge  one-cycle pulse in the cycle sclk shows a sampling edge
//   shift_edge   one-cycle pulse in the cycle sclk shows a shifting edge
//   busy         high while in LEAD, RUN or TRAIL
//
// Build option: define SCLK_STRETCH_EN to add the hold input (clock
// stretching ahead of leading edges, used to ride out TX data underrun).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | sclk follows cpol, counters cleared, waiting for en
// LEAD  | counting LEAD_HP half-periods before the first SCLK edge
// RUN   | every half-period tick toggles sclk and fires one strobe
// TRAIL | sclk parked at cpol_l for TRAIL_HP half-periods, then IDLE

module spi_sclk_gen #(
    parameter int DIV_W    = 8,
    parameter int LEAD_HP  = 1,
    parameter int TRAIL_HP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic             cpol,
    input  logic             cpha,
`ifdef SCLK_STRETCH_EN
    input  logic             hold,
`endif
    output logic             sclk,
    output logic             sample_edge,
    output logic             shift_edge,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        RUN   = 2'd2,
        TRAIL = 2'd3
    } stateT;

    localparam logic [DIV_W-1:0] ONE        = DIV_W'(1);
    localparam logic [3:0]       LEAD_LAST  = 4'(LEAD_HP - 1);
    localparam logic [3:0]       TRAIL_LAST = 4'(TRAIL_HP - 1);
    // A zero-length lead or trail skips that state entirely so the first
    // edge still lands div_l cycles after start and busy drops right after
    // the last trailing edge.
    localparam bit               LEAD_SKIP  = (LEAD_HP == 0);
    localparam bit               TRAIL_SKIP = (TRAIL_HP == 0);

    stateT            state;
    stateT            stateNext;
    logic [DIV_W-1:0] divCnt;
    logic [DIV_W-1:0] divCntNext;
    logic [3:0]       hpCnt;
    logic [3:0]       hpCntNext;
    logic [DIV_W-1:0] divL;
    logic [DIV_W-1:0] divLNext;
    logic             cpolL;
    logic             cpolLNext;
    logic             cphaL;
    logic             cphaLNext;
    logic             sclkNext;
    logic             sampleNext;
    logic             shiftNext;

    logic [DIV_W-1:0] divLast;
    logic             atLast;
    logic             nextIsLeading;
    logic             holdReq;
    logic             stall;
    logic             tick;

`ifdef SCLK_STRETCH_EN
    assign holdReq = hold;
`else
    assign holdReq = 1'b0;
`endif

    assign divLast       = divL - ONE;
    assign atLast        = (divCnt == divLast);
    // sclk at its idle level means the next toggle leaves cpol_l: leading edge.
    assign nextIsLeading = (sclk == cpolL);
    // Only a pending leading edge may be stretched; the count parks at its
    // last value so the edge fires on the first cycle hold is released.
    assign stall         = (state == RUN) && nextIsLeading && holdReq;
    assign tick          = (state != IDLE) && atLast && !stall;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            divCnt      <= '0;
            hpCnt       <= '0;
            divL        <= ONE;
            cpolL       <= 1'b0;
            cphaL       <= 1'b0;
            sclk        <= 1'b0;
            sample_edge <= 1'b0;
            shift_edge  <= 1'b0;
        end else begin
            state       <= stateNext;
            divCnt      <= divCntNext;
            hpCnt       <= hpCntNext;
            divL        <= divLNext;
            cpolL       <= cpolLNext;
            cphaL       <= cphaLNext;
            sclk        <= sclkNext;
            sample_edge <= sampleNext;
            shift_edge  <= shiftNext;
        end
    end

    always_comb begin
        stateNext  = state;
        divCntNext = divCnt;
        hpCntNext  = hpCnt;
        divLNext   = divL;
        cpolLNext  = cpolL;
        cphaLNext  = cphaL;
        sclkNext   = sclk;
        sampleNext = 1'b0;
        shiftNext  = 1'b0;

        // Divider runs continuously across LEAD/RUN/TRAIL so half-periods
        // stay aligned through state changes.
        if (tick) begin
            divCntNext = '0;
        end else if (!atLast) begin
            divCntNext = divCnt + ONE;
        end

        unique case (state)
            IDLE: begin
                divCntNext = '0;
                hpCntNext  = '0;
                sclkNext   = cpol;
                if (en) begin
                    divLNext  = (div == '0) ? ONE : div;
                    cpolLNext = cpol;
                    cphaLNext = cpha;
                    stateNext = LEAD_SKIP ? RUN : LEAD;
                end
            end

            LEAD: begin
                sclkNext = cpolL;
                if (tick) begin
                    if (hpCnt == LEAD_LAST) begin
                        hpCntNext = '0;
                        stateNext = RUN;
                    end else begin
                        hpCntNext = hpCnt + 4'd1;
                    end
                end
            end

            RUN: begin
                if (tick) begin
                    sclkNext = ~sclk;
                    if (nextIsLeading) begin
                        sampleNext = ~cphaL;
                        shiftNext  = cphaL;
                    end else begin
                        sampleNext = cphaL;
                        shiftNext  = ~cphaL;
                        // en only matters at a trailing edge, so every
                        // period that started also finishes.
                        if (!en) begin
                            hpCntNext = '0;
                            stateNext = TRAIL_SKIP ? IDLE : TRAIL;
                        end
                    end
                end
            end

            TRAIL: begin
                sclkNext = cpolL;
                if (tick) begin
                    if (hpCnt == TRAIL_LAST) begin
                        hpCntNext = '0;
                        stateNext = IDLE;
                    end else begin
                        hpCntNext = hpCnt + 4'd1;
                    end
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_sclk_gen.sv
// tb_spi_sclk_gen
//
// Purpose: self-checking bench for spi_sclk_gen. A table of transfers
// (inputs plus hand-derived half-period and period count) drives the DUT;
// for each transfer the expected output events are pushed to a scoreboard
// queue and a negedge monitor pops and compares every observed event
// (sclk change, busy change or strobe). Reset corner cases are hand-written.
//
// Ports: none (top-level bench). Define SCLK_STRETCH_EN to exercise hold.

module tb_spi_sclk_gen;

    localparam int DIV_W_TB    = 8;
    localparam int LEAD_HP_TB  = 1;
    localparam int TRAIL_HP_TB = 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic [DIV_W_TB-1:0] div;
    logic                cpol;
    logic                cpha;
`ifdef SCLK_STRETCH_EN
    logic                hold;
`endif
    logic                sclk;
    logic                sample_edge;
    logic                shift_edge;
    logic                busy;

    spi_sclk_gen #(
        .DIV_W    (DIV_W_TB),
        .LEAD_HP  (LEAD_HP_TB),
        .TRAIL_HP (TRAIL_HP_TB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .div         (div),
        .cpol        (cpol),
        .cpha        (cpha),
`ifdef SCLK_STRETCH_EN
        .hold        (hold),
`endif
        .sclk        (sclk),
        .sample_edge (sample_edge),
        .shift_edge  (shift_edge),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // One transfer: inputs, en high time, optional mid-transfer div change,
    // optional hold length; expD/expN are the expected half-period and the
    // expected number of SCLK periods, worked out by hand.
    typedef struct {
        int div;
        bit cpol;
        bit cpha;
        int enLen;
        int newDiv;
        int stretch;
        int expD;
        int expN;
    } vec_t;

    // val = {sclk, sample_edge, shift_edge, busy}
    typedef struct {
        int         cyc;
        logic [3:0] val;
    } ev_t;

    ev_t  expQ[$];
    vec_t vecs[$];

    int   nChecks   = 0;
    int   nFail     = 0;
    int   sampleCnt = 0;
    int   shiftCnt  = 0;
    bit   monEn     = 1'b0;
    bit   idleSclk  = 1'b0;
    logic prevSclk  = 1'b0;
    logic prevBusy  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected events for one transfer starting in cycle s (en first high).
    task automatic pushTransfer(input int s, input int d, input int n, input bit cp,
                                input bit ch, input int stretch);
        int t;
        int f;
        bit lead;
        bit smp;
        expQ.push_back('{s + 1, {cp, 1'b0, 1'b0, 1'b1}});
        f = s + 1 + (LEAD_HP_TB + 1) * d;
        t = f;
        for (int k = 0; k < 2 * n; k++) begin
            // k = 4 is the third leading edge, the one a hold run delays
            t    = f + k * d + ((k >= 4) ? stretch : 0);
            lead = (k % 2 == 0);
            smp  = lead ? !ch : ch;
            expQ.push_back('{t, {(lead ? !cp : cp), smp, !smp, 1'b1}});
        end
        expQ.push_back('{t + TRAIL_HP_TB * d, {cp, 1'b0, 1'b0, 1'b0}});
    endtask

    task automatic setInputs(input int d, input bit cp, input bit ch);
        @(posedge clk); #1;
        div  = DIV_W_TB'(d);
        cpol = cp;
        cpha = ch;
        if (cp != idleSclk) begin
            expQ.push_back('{cyc + 1, {cp, 1'b0, 1'b0, 1'b0}});
            idleSclk = cp;
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic finishTransfer(input int n);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 600 && !idle; i++) begin
            @(posedge clk); #1;
            if (busy === 1'b0) idle = 1'b1;
        end
        check("busy_release", 32'(idle), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(expQ.size()), 32'd0);
        check("sample_count", 32'(sampleCnt), 32'(n));
        check("shift_count", 32'(shiftCnt), 32'(n));
        expQ.delete();
    endtask

    task automatic runVector(input vec_t v);
        int s;
        setInputs(v.div, v.cpol, v.cpha);
        @(posedge clk); #1;
        s         = cyc;
        sampleCnt = 0;
        shiftCnt  = 0;
        pushTransfer(s, v.expD, v.expN, v.cpol, v.cpha, v.stretch);
        en = 1'b1;
        for (int i = 1; i <= v.enLen; i++) begin
            @(posedge clk); #1;
            if (i == 3 && v.newDiv >= 0) div = DIV_W_TB'(v.newDiv);
`ifdef SCLK_STRETCH_EN
            // with div=2 the third leading tick is due in cycle s+12
            if (v.stretch > 0 && i == 12) hold = 1'b1;
            if (v.stretch > 0 && i == 12 + v.stretch) hold = 1'b0;
`endif
            if (i == v.enLen) en = 1'b0;
        end
        finishTransfer(v.expN);
    endtask

    // Scoreboard consumer.
    initial begin
        ev_t ev;
        forever begin
            @(negedge clk);
            if (monEn && (sclk !== prevSclk || busy !== prevBusy ||
                          sample_edge === 1'b1 || shift_edge === 1'b1)) begin
                if (sample_edge === 1'b1) sampleCnt++;
                if (shift_edge === 1'b1) shiftCnt++;
                if (expQ.size() == 0) begin
                    nChecks++;
                    nFail++;
                    $display("FAIL unexpected_event: cycle %0d sclk=%b sample=%b shift=%b busy=%b, no event expected",
                             cyc, sclk, sample_edge, shift_edge, busy);
                end else begin
                    ev = expQ.pop_front();
                    check("event_cycle", 32'(cyc), 32'(ev.cyc));
                    check("event_outputs", 32'({sclk, sample_edge, shift_edge, busy}), 32'(ev.val));
                end
            end
            prevSclk = sclk;
            prevBusy = busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        rst  = 1'b1;
        en   = 1'b1;
        div  = DIV_W_TB'(2);
        cpol = 1'b0;
        cpha = 1'b0;
`ifdef SCLK_STRETCH_EN
        hold = 1'b0;
`endif
        monEn = 1'b1;

        // {div, cpol, cpha, enLen, newDiv, stretch, expD, expN}
        vecs.push_back('{2, 1'b0, 1'b0, 32, -1, 0, 2, 8});  // 8 periods, mode 0
        vecs.push_back('{1, 1'b1, 1'b1, 10, -1, 0, 1, 5});  // fastest clock, mode 3
        vecs.push_back('{3, 1'b0, 1'b1, 14, -1, 0, 3, 2});  // en drops 1 cycle after a leading edge
        vecs.push_back('{0, 1'b0, 1'b0,  6, -1, 0, 1, 3});  // div=0 ...
        vecs.push_back('{1, 1'b0, 1'b0,  6, -1, 0, 1, 3});  // ... matches div=1
        vecs.push_back('{2, 1'b0, 1'b0, 12,  5, 0, 2, 3});  // div changed while busy
        vecs.push_back('{5, 1'b0, 1'b0, 20, -1, 0, 5, 2});  // new div takes effect
        vecs.push_back('{4, 1'b1, 1'b0,  2, -1, 0, 4, 1});  // en drops during LEAD
`ifdef SCLK_STRETCH_EN
        vecs.push_back('{2, 1'b0, 1'b0, 22, -1, 6, 2, 4});  // hold 6 cycles before 3rd leading edge
`endif

        // Reset held with en high: outputs quiet, start on the cycle after release.
        @(posedge clk); #1;
        check("reset_outputs_c1", 32'({sclk, sample_edge, shift_edge, busy}), 32'd0);
        @(posedge clk); #1;
        check("reset_outputs_c2", 32'({sclk, sample_edge, shift_edge, busy}), 32'd0);
        s         = cyc;
        sampleCnt = 0;
        shiftCnt  = 0;
        pushTransfer(s, 2, 1, 1'b0, 1'b0, 0);
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            if (i == 6) en = 1'b0;
        end
        finishTransfer(1);

        // Reset asserted in the cycle of the first leading tick: no strobe escapes.
        setInputs(2, 1'b0, 1'b0);
        monEn = 1'b0;
        @(posedge clk); #1;
        en = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("pre_reset_state", 32'({sclk, sample_edge, shift_edge, busy}), 32'b0001);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_reset_outputs", 32'({sclk, sample_edge, shift_edge, busy}), 32'd0);
        rst = 1'b0;
        en  = 1'b0;
        @(posedge clk); #1;
        check("post_reset_idle", 32'({sclk, sample_edge, shift_edge, busy}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        expQ.delete();
        monEn = 1'b1;

        for (int v = 0; v < vecs.size(); v++) begin
            runVector(vecs[v]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/spi_sclk_gen.md
Name: spi_sclk_gen

Overview:
Generates SCLK and one-cycle edge strobes for the SPI master. It sits directly upstream of the data word counter and shift register: sample_edge drives their SampleEdge input, and busy gates their count enable. Programmable divider, CPOL/CPHA modes, lead and trail delays around each transfer.

Parameters:
DIV_W, 8, width of the div input
LEAD_HP, 1, SCLK half-periods from transfer start to first SCLK edge (range 0..15)
TRAIL_HP, 1, SCLK half-periods from last SCLK edge to return to IDLE (range 0..15)

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
en  in  1  level; high = run SCLK, low = finish current period and stop
div  in  DIV_W  SCLK half-period in clk cycles; latched on IDLE->LEAD; 0 treated as 1
cpol  in  1  SCLK idle level; latched on IDLE->LEAD
cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; latched on IDLE->LEAD
sclk  out  1  SPI clock, registered
sample_edge  out  1  1-cycle pulse, in the cycle sclk first shows a sampling edge
shift_edge  out  1  1-cycle pulse, in the cycle sclk first shows a shifting edge
busy  out  1  high in LEAD, RUN, TRAIL

Behaviour:
- Reset: state=IDLE, sclk=0, sample_edge=0, shift_edge=0, busy=0, divider count=0, half-period count=0.
- Half-period tick: counter runs 0..div_l-1 and wraps; tick when count==div_l-1. Counter is held at 0 in IDLE.
- IDLE: sclk follows cpol (registered, one cycle of latency). en high -> latch div/cpol/cpha, go to LEAD, busy=1 on the next cycle.
- LEAD: counts LEAD_HP ticks, then goes to RUN. With LEAD_HP=0, go to RUN immediately without a tick.
- RUN: each tick toggles sclk.
  - Leading edge = sclk leaves cpol_l. Trailing edge = sclk returns to cpol_l.
  - cpha_l=0: leading edge fires sample_edge, trailing edge fires shift_edge.
  - cpha_l=1: leading edge fires shift_edge, trailing edge fires sample_edge.
  - Pulses are registered together with sclk in the same clk edge.
- Stop: en is checked only at a trailing-edge tick. If en is low there, go to TRAIL. A full SCLK period always completes, and every period yields exactly one sample_edge and one shift_edge.
- en dropping in LEAD: LEAD completes, one full SCLK period runs, then TRAIL.
- TRAIL: counts TRAIL_HP ticks with sclk=cpol_l, then goes to IDLE with busy=0. en high during TRAIL is ignored; a new start is taken only from IDLE.
- SCLK period: 2*div_l clk cycles. First SCLK edge occurs (LEAD_HP+1)*div_l cycles after the IDLE->LEAD cycle.
- div, cpol and cpha changes while busy have no effect until the next start.
- rst mid-transfer: next cycle is the reset state; no strobes are emitted.
- sample_edge and shift_edge are never high in the same cycle.

Optional Feature:
SCLK_STRETCH_EN
- Defined: adds input port hold (1 bit).
  - In RUN, while hold=1 and the next tick would be a leading edge, the divider count freezes at div_l-1 and sclk stays at cpol_l.
  - The leading edge fires on the first cycle hold=0.
  - Trailing edges are never held.
  - Used to absorb TX data underrun.
- Undefined: no hold port; SCLK free-runs as above.

Test Plan:
- rst=1 for 2 cycles with en=1 -> sclk=0, busy=0, no strobes; after release, start occurs on the next cycle.
- div=2, cpol=0, cpha=0, LEAD_HP=1, en high for exactly 8 SCLK periods -> first rising sclk 4 cycles after start; period 4 cycles; 8 sample_edge on rising edges, 8 shift_edge on falling edges; busy falls 2 cycles after the last falling edge.
- div=1, cpol=1, cpha=1 -> sclk idles high, period 2 cycles; sample_edge on rising (trailing) edges, shift_edge on falling edges.
- en dropped 1 cycle after a leading edge (div=3) -> period completes with its trailing-edge strobe, then TRAIL; equal sample_edge and shift_edge counts.
- div=0 -> behaves identically to div=1; div changed to 5 while busy -> period unchanged until the next transfer.
- SCLK_STRETCH_EN defined, hold=1 for 6 cycles before the 3rd leading edge -> sclk stays at cpol for 6 extra cycles; strobe count unchanged.
